rf_access_arbiter: RTL and testbench

//  Shares the single register-file port between two requesters: port 0 = system

---
 rtl/rf_access_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_rf_access_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//   Shares the single register-file port between two requesters:
//   port 0 = system command controller, port 1 = background config/scan engine.
//   Round-robin grant, one outstanding access at a time. Read data is routed
//   back to the requester that issued the read. All outputs are registered.
//
// Ports
//   CLK, RST             reference clock, synchronous active-low reset
//   reqN_valid/wr/addr/wdata  (N=0,1) request, held with its fields until reqN_ack
//   reqN_ack             one-cycle pulse: request issued to the register file
//   rspN_data/rspN_valid read response for requester N (data holds between pulses)
//   Address, WrEn, RdEn, WrData   register-file command side
//   RdData, RdData_Valid          register-file read return
//   timeout_err          one-cycle pulse: read response timed out
//
// Configuration
//   RF_ARB_TIMEOUT_EN    when defined, a read waiting TIMEOUT_CYC cycles without
//                        RdData_Valid completes with data 0 and timeout_err=1.
//                        When undefined, WAIT_RD waits indefinitely and
//                        timeout_err is tied 0.
module rf_access_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR        = 4
`ifdef RF_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid,
  input  logic                  req0_wr,
  input  logic [ADDR-1:0]       req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ack,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_valid,
  input  logic                  req1_valid,
  input  logic                  req1_wr,
  input  logic [ADDR-1:0]       req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ack,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_valid,
  output logic [ADDR-1:0]       Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic                  timeout_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;    // port granted most recently
  logic                  owner_q, owner_d;  // port owning the current access
  logic [ADDR-1:0]       addr_q, addr_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic                  rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic                  grant1;
  logic                  sel_wr;

`ifdef RF_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC) < 4) ? 4 : $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wren_d       = 1'b0;
    rden_d       = 1'b0;
    wrdata_d     = '0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    grant1       = 1'b0;
    sel_wr       = 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    tout_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Port 1 wins when it is alone, or on a tie when port 0 won last.
          grant1   = req1_valid && (!req0_valid || !last_q);
          sel_wr   = grant1 ? req1_wr : req0_wr;
          owner_d  = grant1;
          last_d   = grant1;
          addr_d   = grant1 ? req1_addr : req0_addr;
          wren_d   = sel_wr;
          rden_d   = !sel_wr;
          wrdata_d = sel_wr ? (grant1 ? req1_wdata : req0_wdata) : '0;
          ack0_d   = !grant1;
          ack1_d   = grant1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        // Registered WrEn still carries the latched access direction here.
        state_d = wren_q ? IDLE : WAIT_RD;
`ifdef RF_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      WAIT_RD: begin
        if (RdData_Valid) begin
          if (owner_q) begin
            rsp1_data_d  = RdData;
            rsp1_valid_d = 1'b1;
          end else begin
            rsp0_data_d  = RdData;
            rsp0_valid_d = 1'b1;
          end
          state_d = IDLE;
        end
`ifdef RF_ARB_TIMEOUT_EN
        // Data arriving in the expiry cycle takes priority over the timeout.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          if (owner_q) begin
            rsp1_data_d  = '0;
            rsp1_valid_d = 1'b1;
          end else begin
            rsp0_data_d  = '0;
            rsp0_valid_d = 1'b1;
          end
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;  // port 0 wins the first tie
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      wrdata_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
`ifdef RF_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      tout_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wren_q       <= wren_d;
      rden_q       <= rden_d;
      wrdata_q     <= wrdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
`ifdef RF_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      tout_q       <= tout_d;
`endif
    end
  end

  assign req0_ack   = ack0_q;
  assign req1_ack   = ack1_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign Address    = addr_q;
  assign WrEn       = wren_q;
  assign RdEn       = rden_q;
  assign WrData     = wrdata_q;
`ifdef RF_ARB_TIMEOUT_EN
  assign timeout_err = tout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_access_arbiter.sv
module tb_rf_access_arbiter;

  logic       CLK, RST;
  logic       req0_valid, req0_wr, req0_ack, rsp0_valid;
  logic [3:0] req0_addr;
  logic [7:0] req0_wdata, rsp0_data;
  logic       req1_valid, req1_wr, req1_ack, rsp1_valid;
  logic [3:0] req1_addr;
  logic [7:0] req1_wdata, rsp1_data;
  logic [3:0] Address;
  logic       WrEn, RdEn, RdData_Valid, timeout_err;
  logic [7:0] WrData, RdData;

  int n_checks = 0;
  int n_bad    = 0;

  rf_access_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .rsp0_data(rsp0_data),
    .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .rsp1_data(rsp1_data),
    .rsp1_valid(rsp1_valid),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic       exp_port;
    logic       early;

    RST = 1'b0;
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 4'h3; req0_wdata = 8'h5A;
    req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 4'h7; req1_wdata = 8'hA5;
    RdData = 8'h00; RdData_Valid = 1'b0;

    // Reset with both requests pending
    tick(); tick();
    check("rst_ack",    {req1_ack, req0_ack}, 2'b00);
    check("rst_strobe", {WrEn, RdEn}, 2'b00);
    check("rst_addr",   Address, 4'h0);
    check("rst_wrdata", WrData, 8'h00);
    check("rst_rspv",   {timeout_err, rsp1_valid, rsp0_valid}, 3'b000);
    check("rst_rspd",   {rsp1_data, rsp0_data}, 16'h0000);

    // First tie after reset goes to port 0: write addr 3 data 5A
    RST = 1'b1;
    tick();
    check("wr0_ack",    {req1_ack, req0_ack}, 2'b01);
    check("wr0_strobe", {WrEn, RdEn}, 2'b10);
    check("wr0_addr",   Address, 4'h3);
    check("wr0_data",   WrData, 8'h5A);
    req0_valid = 1'b0;
    tick();
    check("wr0_gap",    {req1_ack, req0_ack, WrEn}, 3'b000);
    tick();
    check("wr1_ack",    {req1_ack, req0_ack}, 2'b10);
    check("wr1_addr",   Address, 4'h7);
    check("wr1_data",   WrData, 8'hA5);

    // Port 1 presents a read of addr 2 on the edge that samples its ack
    req1_wr = 1'b0; req1_addr = 4'h2;
    tick();
    check("rd1_gap",    {req1_ack, req0_ack}, 2'b00);
    tick();
    check("rd1_ack",    {req1_ack, req0_ack}, 2'b10);
    check("rd1_strobe", {WrEn, RdEn}, 2'b01);
    check("rd1_addr",   Address, 4'h2);
    check("rd1_wrdata", WrData, 8'h00);
    req1_valid = 1'b0;
    tick(); tick();
    check("rd1_wait",   {RdEn, rsp1_valid, rsp0_valid}, 3'b000);
    check("rd1_hold",   Address, 4'h2);
    RdData = 8'hC3; RdData_Valid = 1'b1;
    tick();
    check("rd1_rspv",   {rsp1_valid, rsp0_valid}, 2'b10);
    check("rd1_rspd",   rsp1_data, 8'hC3);
    RdData_Valid = 1'b0;
    tick();
    check("rd1_pulse",  {rsp1_valid, rsp0_valid}, 2'b00);
    check("rd1_keep",   rsp1_data, 8'hC3);

    // Fairness: both ports write continuously; port 1 won last, so 0,1,0,1...
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 4'hA; req0_wdata = 8'h10;
    req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 4'hB; req1_wdata = 8'h20;
    for (int i = 0; i < 8; i++) begin
      exp_port = (i % 2) == 1;
      tick();
      check("rr_ack",  {req1_ack, req0_ack}, exp_port ? 2'b10 : 2'b01);
      check("rr_wren", WrEn, 1'b1);
      check("rr_addr", Address, exp_port ? 4'hB : 4'hA);
      check("rr_data", WrData, exp_port ? 8'h20 + 8'(i / 2) : 8'h10 + 8'(i / 2));
      if (exp_port) req1_wdata = req1_wdata + 8'h01;
      else          req0_wdata = req0_wdata + 8'h01;
      if (i == 7) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
      check("rr_gap",  {req1_ack, req0_ack, WrEn}, 3'b000);
    end

    // Spurious RdData_Valid in IDLE
    RdData = 8'hFF; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    check("spur_rspv", {rsp1_valid, rsp0_valid}, 2'b00);
    check("spur_keep", {rsp1_data, rsp0_data}, 16'hC300);

    // Port 0 read answered in the first wait cycle; port 1 data untouched
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 4'h5;
    tick();
    check("rd0_ack",  {req1_ack, req0_ack, RdEn}, 3'b011);
    check("rd0_addr", Address, 4'h5);
    req0_valid = 1'b0;
    tick();
    RdData = 8'h3C; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    check("rd0_rspv", {rsp1_valid, rsp0_valid}, 2'b01);
    check("rd0_rspd", {rsp1_data, rsp0_data}, 16'hC33C);
    tick();

    // Read of the top address with no RdData_Valid
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 4'hF;
    tick();
    check("to_ack",  {req1_ack, req0_ack, RdEn}, 3'b011);
    check("to_addr", Address, 4'hF);
    req0_valid = 1'b0;
    tick();
    early = 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      early = early | rsp0_valid | rsp1_valid | timeout_err;
    end
    check("to_early", early, 1'b0);
    tick();
    check("to_fire",  {timeout_err, rsp1_valid, rsp0_valid}, 3'b101);
    check("to_data",  rsp0_data, 8'h00);
    RdData = 8'hAA; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    check("to_late",  {timeout_err, rsp1_valid, rsp0_valid}, 3'b000);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      early = early | rsp0_valid | rsp1_valid | timeout_err;
    end
    check("wait_quiet", early, 1'b0);
    RdData = 8'h99; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    check("wait_rspv", {timeout_err, rsp1_valid, rsp0_valid}, 3'b001);
    check("wait_rspd", rsp0_data, 8'h99);
`endif
    tick();

    // Reset during WAIT_RD, then a late RdData_Valid
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 4'h0;
    tick();
    check("rr_rd_ack", {req1_ack, req0_ack, RdEn}, 3'b101);
    req1_valid = 1'b0;
    tick(); tick();
    RST = 1'b0;
    tick();
    RST = 1'b1; RdData = 8'h77; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    check("mid_rst_rspv", {timeout_err, rsp1_valid, rsp0_valid}, 3'b000);
    check("mid_rst_rspd", {rsp1_data, rsp0_data}, 16'h0000);

    // Arbiter is back in IDLE with port 0 favoured on a tie
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 4'h1; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 4'h2; req1_wdata = 8'h22;
    tick();
    check("post_ack0", {req1_ack, req0_ack}, 2'b01);
    check("post_addr0", Address, 4'h1);
    req0_valid = 1'b0;
    tick(); tick();
    check("post_ack1", {req1_ack, req0_ack}, 2'b10);
    check("post_data1", WrData, 8'h22);
    req1_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
